rand_seg_display: RTL and testbench

Downstream consumer of the 8-bit LFSR generator in the seven-segment design. It samples the generator byte at a fixed period and shows the current sample (digits 1:0) and the previous sample (digits 3:2) as hex on a 4-digit multiplexed common-anode display. A freeze switch holds the display and drives the generator's stall input.

---
 rtl/rand_seg_display_if.sv | 30 +++
 rtl/rand_seg_display.sv | 147 ++++++++++++++
 tb/tb_rand_seg_display.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/rand_seg_display_if.sv
// rand_seg_display_if
//   Bundles the generator-facing and display-facing signals of rand_seg_display.
//   master : the display block (consumes q_in/freeze, drives everything else)
//   slave  : the environment (LFSR byte source, switch, display pins)
//   q_in[7:0]    LFSR output byte
//   freeze       raw slide switch (asynchronous to clock)
//   stp          stall request back to the LFSR
//   an[3:0]      anodes, active-low
//   seg[6:0]     cathodes, active-low, seg[0]=a .. seg[6]=g
//   dp           decimal point, active-low
//   sample_tick  one-cycle pulse per capture
interface rand_seg_display_if;
  logic [7:0] q_in;
  logic       freeze;
  logic       stp;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       sample_tick;

  modport master (
    input  q_in, freeze,
    output stp, an, seg, dp, sample_tick
  );

  modport slave (
    output q_in, freeze,
    input  stp, an, seg, dp, sample_tick
  );
endinterface

// File: rtl/rand_seg_display.sv
// rand_seg_display
//   Samples the LFSR byte every SAMPLE_DIV cycles and shows the current sample
//   (digits 1:0) and the previous sample (digits 3:2) as hex on a 4-digit
//   multiplexed common-anode display. A synchronized freeze switch holds the
//   sampling and stalls the generator.
//   clock : single clock, rising edge
//   rst   : synchronous, active-low reset
//   bus   : rand_seg_display_if.master (q_in, freeze in; stp, an, seg, dp,
//           sample_tick out; all outputs registered)
module rand_seg_display #(
  parameter int REFRESH_DIV = 100000,  // cycles per digit slot, >= 2
  parameter int BLANK       = 16,      // dark cycles at slot start, < REFRESH_DIV
  parameter int SAMPLE_DIV  = 50000000 // cycles between captures, >= 2
) (
  input logic                clock,
  input logic                rst,
  rand_seg_display_if.master bus
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int SW = $clog2(SAMPLE_DIV);
  localparam logic [RW-1:0] R_LAST  = RW'(REFRESH_DIV - 1);
  localparam logic [RW-1:0] R_BLANK = RW'(BLANK);
  localparam logic [SW-1:0] S_LAST  = SW'(SAMPLE_DIV - 1);

  // Active-low hex decode, returned as {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic          f1_q, f1_d;
  logic          fz_q, fz_d;
  logic          stp_q, stp_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    cur_q, cur_d;
  logic [7:0]    prev_q, prev_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          tick_q, tick_d;
  logic [3:0]    nibble;
  logic          lit;

  always_comb begin
    // Two-flop synchronizer; stp is one further register stage.
    f1_d  = bus.freeze;
    fz_d  = f1_q;
    stp_d = fz_q;

    // Sampling pauses entirely while frozen and resumes from the held count.
    scnt_d = scnt_q;
    cur_d  = cur_q;
    prev_d = prev_q;
    tick_d = 1'b0;
    if (!fz_q) begin
      if (scnt_q == S_LAST) begin
        scnt_d = '0;
        prev_d = cur_q;
        cur_d  = bus.q_in;
        tick_d = 1'b1;
      end else begin
        scnt_d = scnt_q + 1'b1;
      end
    end

    // Refresh keeps scanning regardless of freeze or captures.
    if (rcnt_q == R_LAST) begin
      rcnt_d = '0;
      idx_d  = idx_q + 2'd1;
    end else begin
      rcnt_d = rcnt_q + 1'b1;
      idx_d  = idx_q;
    end

    case (idx_q)
      2'd0:    nibble = cur_q[3:0];
      2'd1:    nibble = cur_q[7:4];
      2'd2:    nibble = prev_q[3:0];
      default: nibble = prev_q[7:4];
    endcase

    // Segments are not blanked; only the anodes are, which is enough to hide
    // the digit change at the slot boundary.
    lit   = (rcnt_q >= R_BLANK);
    seg_d = hex_decode(nibble);
    an_d  = lit ? ~(4'b0001 << idx_q) : 4'b1111;
    dp_d  = !((idx_q == 2'd0) && fz_q && lit);
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      f1_q   <= 1'b0;
      fz_q   <= 1'b0;
      stp_q  <= 1'b0;
      scnt_q <= '0;
      rcnt_q <= '0;
      idx_q  <= 2'd0;
      cur_q  <= 8'h00;
      prev_q <= 8'h00;
      an_q   <= 4'b1111;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      f1_q   <= f1_d;
      fz_q   <= fz_d;
      stp_q  <= stp_d;
      scnt_q <= scnt_d;
      rcnt_q <= rcnt_d;
      idx_q  <= idx_d;
      cur_q  <= cur_d;
      prev_q <= prev_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      tick_q <= tick_d;
    end
  end

  assign bus.stp         = stp_q;
  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.sample_tick = tick_q;

endmodule

// File: tb/tb_rand_seg_display.sv
// tb_rand_seg_display
//   Directed bench for rand_seg_display with REFRESH_DIV=8, BLANK=2,
//   SAMPLE_DIV=20. Edges are counted from each reset release; after edge k
//   the refresh counter is k mod 8 and the digit index is (k/8) mod 4, so the
//   outputs seen after edge e reflect the counter state after edge e-1.
module tb_rand_seg_display;
  logic clock;
  logic rst;
  int   errors;
  int   checks;
  int   edge_n;
  int   t1, t2, nt;

  rand_seg_display_if bus ();

  rand_seg_display #(
    .REFRESH_DIV(8),
    .BLANK      (2),
    .SAMPLE_DIV (20)
  ) dut (
    .clock(clock),
    .rst  (rst),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h want %h", tag, edge_n, got, exp);
    end
  endtask

  // One rising edge, then sample at the following falling edge.
  task automatic cyc();
    @(posedge clock);
    edge_n++;
    @(negedge clock);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_an", 32'(bus.an), 32'h0000000F);
    chk("rst_seg", 32'(bus.seg), 32'h0000007F);
    chk("rst_dp", 32'(bus.dp), 32'd1);
    chk("rst_stp", 32'(bus.stp), 32'd0);
    chk("rst_tick", 32'(bus.sample_tick), 32'd0);
  endtask

  // Run up to edge `last`, checking the full display scan against the
  // expected segment codes for digits 0..3 (tab = {d3,d2,d1,d0}).
  task automatic scan_check(input int last, input logic [27:0] tab, input logic frz,
                            input int tick_edge);
    int r, i;
    logic [3:0] an_e;
    logic [6:0] seg_e;
    logic       dp_e;
    while (edge_n < last) begin
      cyc();
      r = (edge_n - 1) % 8;
      i = ((edge_n - 1) / 8) % 4;
      an_e = 4'hF;
      if (r >= 2) an_e[i] = 1'b0;
      seg_e = tab[i*7 +: 7];
      dp_e = !(frz && (i == 0) && (r >= 2));
      chk("scan_an", 32'(bus.an), 32'(an_e));
      chk("scan_seg", 32'(bus.seg), 32'(seg_e));
      chk("scan_dp", 32'(bus.dp), 32'(dp_e));
      chk("scan_stp", 32'(bus.stp), 32'(frz));
      chk("scan_tick", 32'(bus.sample_tick), 32'(edge_n == tick_edge));
    end
  endtask

  // Run up to edge `last`, recording the first two capture pulses.
  task automatic run_ticks(input int last);
    t1 = 0;
    t2 = 0;
    nt = 0;
    while (edge_n < last) begin
      cyc();
      if (bus.sample_tick) begin
        nt++;
        if (nt == 1) t1 = edge_n;
        if (nt == 2) t2 = edge_n;
      end
      if (edge_n == 20 && last == 41) bus.q_in = 8'hA5;
      if (edge_n == 78) chk("stp_hold", 32'(bus.stp), 32'd1);
      if (edge_n == 79) chk("stp_fall", 32'(bus.stp), 32'd0);
    end
  endtask

  localparam logic [27:0] TAB_ZERO = {7'h40, 7'h40, 7'h40, 7'h40};
  localparam logic [27:0] TAB_A53C = {7'h30, 7'h46, 7'h08, 7'h12}; // 5,A,C,3
  localparam logic [27:0] TAB_5AA5 = {7'h08, 7'h12, 7'h12, 7'h08}; // A,5,5,A

  initial begin
    errors = 0;
    checks = 0;
    edge_n = 0;
    rst = 1'b0;
    bus.freeze = 1'b1;
    bus.q_in = 8'h77;

    // Reset held for three edges with freeze high and junk on q_in.
    repeat (3) cyc();
    chk_reset_outputs();
    $display("reset: an=%b seg=%h dp=%b", bus.an, bus.seg, bus.dp);

    // Release; display shows 0000 with blanking before the first capture.
    @(negedge clock);
    rst = 1'b1;
    bus.freeze = 1'b0;
    bus.q_in = 8'h3C;
    edge_n = 0;
    scan_check(19, TAB_ZERO, 1'b0, 0);
    $display("post-reset scan to edge %0d", edge_n);

    // Captures at edges 20 and 40; q_in switches to A5 in between.
    run_ticks(41);
    chk("cap_count", 32'(nt), 32'd2);
    chk("cap_first", 32'(t1), 32'd20);
    chk("cap_second", 32'(t2), 32'd40);
    $display("capture chain: ticks at %0d and %0d", t1, t2);

    // Freeze: stp rises three edges after the switch.
    bus.freeze = 1'b1;
    cyc();
    chk("stp_lat1", 32'(bus.stp), 32'd0);
    cyc();
    chk("stp_lat2", 32'(bus.stp), 32'd0);
    cyc();
    chk("stp_rise", 32'(bus.stp), 32'd1);
    $display("freeze: stp=1 at edge %0d", edge_n);

    // Frozen full scan: digits 5,A,C,3, dp on digit 0 lit phase, no captures.
    scan_check(76, TAB_A53C, 1'b1, 0);
    $display("frozen scan to edge %0d", edge_n);

    // Unfreeze with scnt held at 3: next capture 17 edges after fz falls (78).
    bus.freeze = 1'b0;
    bus.q_in = 8'h5A;
    run_ticks(112);
    chk("resume_count", 32'(nt), 32'd1);
    chk("resume_edge", 32'(t1), 32'd95);
    $display("unfreeze: capture at edge %0d", t1);

    // fz goes high exactly when scnt reaches 19: the capture is skipped.
    bus.freeze = 1'b1;
    bus.q_in = 8'hC3;
    cyc();
    chk("edge_tick_a", 32'(bus.sample_tick), 32'd0);
    cyc();
    chk("edge_tick_b", 32'(bus.sample_tick), 32'd0);
    scan_check(150, TAB_5AA5, 1'b1, 0);
    $display("freeze at capture edge: held to edge %0d", edge_n);

    // Unfreeze: held scnt=19 captures on the first edge with fz low (153).
    bus.freeze = 1'b0;
    bus.q_in = 8'hFF;
    run_ticks(160);
    chk("held19_count", 32'(nt), 32'd1);
    chk("held19_edge", 32'(t1), 32'd153);
    $display("held capture at edge %0d", t1);

    // Mid-operation reset after capturing FF.
    rst = 1'b0;
    cyc();
    chk_reset_outputs();
    $display("mid reset: an=%b seg=%h", bus.an, bus.seg);
    rst = 1'b1;
    bus.q_in = 8'h00;
    edge_n = 0;
    scan_check(32, TAB_ZERO, 1'b0, 20);
    $display("post mid-reset scan to edge %0d", edge_n);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
